// File: rtl/bridge_utils_pkg.sv
// rtl/bridge_utils_pkg.sv - shared types and limits for the AXI-to-APB bridge blocks
package bridge_utils;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_t;

  localparam int APB_SLV_MAX_WAIT = 15;

endpackage

// File: rtl/apb_slv_regfile.sv
// rtl/apb_slv_regfile.sv - word register storage with byte-strobed write and combinational read
module apb_slv_regfile #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB4 completer over a register memory; APB_SLV_ERR_EN enables address error responses
module apb_slave_mem
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int IDX_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(APB_SLV_MAX_WAIT + 1);
  localparam int CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_INIT_I[CNT_W-1:0];

  apb_slv_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    err_q;
  logic                    pready_q, pready_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pslverr_q, pslverr_d;

  logic                    setup;
  logic                    addr_err;
  logic [IDX_W-1:0]        rd_idx;
  logic                    cur_write;
  logic                    cur_err;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    unused_paddr;

  assign setup        = psel && !penable;
  assign unused_paddr = ^paddr;

`ifdef APB_SLV_ERR_EN
  assign addr_err = (paddr[1:0] != 2'b00) || (paddr >= ADDR_WIDTH'(DEPTH * 4));
`else
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = (WAIT_STATES > 0) ? WAIT : READY;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states READY follows setup directly, so the live bus selects the read word.
  assign rd_idx    = (state_q == IDLE) ? paddr[IDX_W+1:2] : idx_q;
  assign cur_write = (state_q == IDLE) ? pwrite : write_q;
  assign cur_err   = (state_q == IDLE) ? addr_err : err_q;

  always_comb begin
    pready_d  = (state_d == READY);
    pslverr_d = (state_d == READY) && cur_err;
    prdata_d  = ((state_d == READY) && !cur_write && !cur_err) ? mem_rdata : '0;
  end

  assign mem_we = (state_q == READY) && write_q && !err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      if (state_q == IDLE && setup) begin
        write_q <= pwrite;
        idx_q   <= paddr[IDX_W+1:2];
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        err_q   <= addr_err;
      end
    end
  end

  apb_slv_regfile #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .wstrb_i (strb_q),
    .raddr_i (rd_idx),
    .rdata_o (mem_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem (2 and 0 wait-state instances)
module tb_apb_slave_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        psel2 = 0, pen2 = 0, pwr2 = 0;
  logic [31:0] paddr2 = 0, pwdata2 = 0, prdata2;
  logic [3:0]  pstrb2 = 0;
  logic        pready2, pslverr2;

  logic        psel0 = 0, pen0 = 0, pwr0 = 0;
  logic [31:0] paddr0 = 0, pwdata0 = 0, prdata0;
  logic [3:0]  pstrb0 = 0;
  logic        pready0, pslverr0;

  int checks = 0;
  int failures = 0;

  logic [31:0] m2 [16];
  logic [31:0] m0 [16];

  always #5 clk = ~clk;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .psel(psel2), .penable(pen2), .pwrite(pwr2), .paddr(paddr2),
    .pwdata(pwdata2), .pstrb(pstrb2), .prdata(prdata2), .pready(pready2), .pslverr(pslverr2)
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(pen0), .pwrite(pwr0), .paddr(paddr0),
    .pwdata(pwdata0), .pstrb(pstrb0), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  typedef struct {
    bit          w;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] a);
`ifdef APB_SLV_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'd64);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic get_ready(input bit w);
    return w ? pready0 : pready2;
  endfunction
  function automatic logic get_err(input bit w);
    return w ? pslverr0 : pslverr2;
  endfunction
  function automatic logic [31:0] get_rdata(input bit w);
    return w ? prdata0 : prdata2;
  endfunction

  task automatic set_bus(input bit w, input logic s, input logic e, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (w) begin
      psel0 = s; pen0 = e; pwr0 = wr; paddr0 = a; pwdata0 = d; pstrb0 = st;
    end else begin
      psel2 = s; pen2 = e; pwr2 = wr; paddr2 = a; pwdata2 = d; pstrb2 = st;
    end
  endtask

  // One full APB transfer; w selects the zero-wait instance. Checks timing and the model.
  task automatic xfer(input bit w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, output logic [31:0] rd, output logic er);
    int n;
    bit got;
    logic [31:0] exp_rd;
    bit exp_er;
    int idx;
    @(posedge clk); #1;
    chk("idle_pready", get_ready(w), 1'b0);
    chk("idle_prdata", get_rdata(w), 32'h0);
    set_bus(w, 1, 0, wr, a, d, st);
    @(posedge clk); #1;
    set_bus(w, 1, 1, wr, a, ~d, st);
    got = 0;
    n = 0;
    while (!got && n < 40) begin
      if (get_ready(w)) got = 1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("pready_seen", got, 1'b1);
    chk("wait_cycles", n, w ? 0 : 2);
    rd = get_rdata(w);
    er = get_err(w);
    set_bus(w, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    idx = int'(a[5:2]);
    exp_er = model_err(a);
    exp_rd = 32'h0;
    if (!exp_er && !wr) exp_rd = w ? m0[idx] : m2[idx];
    if (!exp_er && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) begin
          if (w) m0[idx][8*b +: 8] = d[8*b +: 8];
          else   m2[idx][8*b +: 8] = d[8*b +: 8];
        end
      end
    end
    chk("model_pslverr", er, exp_er);
    if (!wr) chk("model_prdata", rd, exp_rd);
  endtask

  task automatic clear_models();
    for (int i = 0; i < 16; i++) begin
      m2[i] = 32'h0;
      m0[i] = 32'h0;
    end
  endtask

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic        er;
    bit          macro_on;
    bit          w, wr;
    logic [31:0] a, d;
    logic [3:0]  st;

`ifdef APB_SLV_ERR_EN
    macro_on = 1'b1;
`else
    macro_on = 1'b0;
`endif

    clear_models();
    tbl.push_back('{0, 0, 32'h0,  32'h0,        4'h0, 32'h0, 0});
    tbl.push_back('{0, 1, 32'h8,  32'hDEADBEEF, 4'hF, 32'h0, 0});
    tbl.push_back('{0, 1, 32'h8,  32'h000000AA, 4'h1, 32'h0, 0});
    tbl.push_back('{0, 0, 32'h8,  32'h0,        4'h0, 32'hDEADBEAA, 0});
    tbl.push_back('{1, 1, 32'h4,  32'hA5A55A5A, 4'hF, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h4,  32'h0,        4'h0, 32'hA5A55A5A, 0});
    tbl.push_back('{0, 1, 32'h0,  32'h11111111, 4'hF, 32'h0, 0});
    tbl.push_back('{0, 1, 32'h40, 32'h22222222, 4'hF, 32'h0, macro_on});
    tbl.push_back('{0, 0, 32'h0,  32'h0,        4'h0, macro_on ? 32'h11111111 : 32'h22222222, 0});
    tbl.push_back('{0, 0, 32'h41, 32'h0,        4'h0, macro_on ? 32'h0 : 32'h22222222, macro_on});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready2", pready2, 1'b0);
    chk("rst_prdata2", prdata2, 32'h0);
    chk("rst_pslverr2", pslverr2, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_pready0", pready0, 1'b0);
    chk("rst_pslverr0", pslverr0, 1'b0);

    foreach (tbl[i]) begin
      xfer(tbl[i].w, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, rd, er);
      chk($sformatf("tbl%0d_pslverr", i), er, tbl[i].exp_err);
      if (!tbl[i].wr) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
    end

    // psel dropped during WAIT: no completion and no write
    @(posedge clk); #1;
    set_bus(0, 1, 0, 1, 32'hC, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    set_bus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_pready", pready2, 1'b0);
      @(posedge clk); #1;
    end
    xfer(0, 0, 32'hC, 32'h0, 4'h0, rd, er);
    chk("abort_read_c", rd, 32'h0);

    // reset in the last WAIT cycle of a write
    @(posedge clk); #1;
    set_bus(0, 1, 0, 1, 32'h10, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    set_bus(0, 1, 1, 1, 32'h10, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_abort_pready", pready2, 1'b0);
    rst = 1'b0;
    set_bus(0, 0, 0, 0, 32'h0, 32'h0, 4'h0);
    clear_models();
    xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("rst_abort_read", rd, 32'h0);
    xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er);
    chk("rst_clears_mem", rd, 32'h0);

    for (int t = 0; t < 300; t++) begin
      w  = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      a  = 32'($urandom_range(0, 71));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      d  = $urandom;
      st = 4'($urandom_range(0, 15));
      xfer(w, wr, a, d, st, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
